// File: rtl/xadc_drp_sequencer.sv
// DRP read sequencer for the XADC. Each end-of-conversion triggers one read of that channel's
// result register, and the code comes out as a tagged single-cycle sample strobe.
// Optional macro XADC_AVG_EN averages 2**AVG_LOG2 consecutive same-channel codes before strobing.
module xadc_drp_sequencer #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int AVG_LOG2       = 2
) (
    input  logic        dclk_in,
    input  logic        reset_in,
    input  logic        eoc_in,
    input  logic [4:0]  channel_in,
    input  logic        clr_err_in,
    output logic [6:0]  daddr_out,
    output logic        den_out,
    output logic        dwe_out,
    output logic [15:0] di_out,
    input  logic [15:0] do_in,
    input  logic        drdy_in,
    output logic [11:0] sample_out,
    output logic [4:0]  sample_chan_out,
    output logic        sample_valid_out,
    output logic        timeout_err_out,
    output logic        ovr_err_out
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_DRDY} state_t;

    localparam logic [9:0] TMO_LAST = 10'(TIMEOUT_CYCLES - 1);

    state_t     state, state_next;
    logic [9:0] tmo_cnt, tmo_cnt_next;
    logic [4:0] chan;
    logic       capture, timeout, overrun;
    logic       unused_do_bits;

    assign dwe_out        = 1'b0;
    assign di_out         = '0;
    assign overrun        = eoc_in && (state != IDLE);
    assign unused_do_bits = ^do_in[3:0];

    // NOTE: sequential state uses <= so every flop samples the values from before the edge.
    always_ff @(posedge dclk_in or posedge reset_in) begin
        if (reset_in) begin
            state   <= IDLE;
            tmo_cnt <= '0;
        end else begin
            state   <= state_next;
            tmo_cnt <= tmo_cnt_next;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next   = state;
        tmo_cnt_next = tmo_cnt;
        den_out      = 1'b0;
        capture      = 1'b0;
        timeout      = 1'b0;
        case (state)
            IDLE: begin
                if (eoc_in) state_next = REQ;
            end
            REQ: begin
                den_out      = 1'b1;
                tmo_cnt_next = '0;
                state_next   = WAIT_DRDY;
            end
            WAIT_DRDY: begin
                tmo_cnt_next = tmo_cnt + 10'd1;
                if (drdy_in) begin
                    capture    = 1'b1;
                    state_next = IDLE;
                end else if (tmo_cnt + 10'd1 == TMO_LAST) begin
                    timeout    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Address and channel tag are latched only when a conversion is accepted.
    always_ff @(posedge dclk_in or posedge reset_in) begin
        if (reset_in) begin
            daddr_out <= '0;
            chan      <= '0;
        end else if (state == IDLE && eoc_in) begin
            daddr_out <= {2'b00, channel_in};
            chan      <= channel_in;
        end
    end

    // Sticky flags: a set event in the same cycle as a clear wins.
    always_ff @(posedge dclk_in or posedge reset_in) begin
        if (reset_in) begin
            timeout_err_out <= 1'b0;
            ovr_err_out     <= 1'b0;
        end else begin
            timeout_err_out <= timeout || (timeout_err_out && !clr_err_in);
            ovr_err_out     <= overrun || (ovr_err_out && !clr_err_in);
        end
    end

`ifdef XADC_AVG_EN
    localparam int               ACC_W = 12 + AVG_LOG2;
    localparam int               CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(1 << AVG_LOG2);

    logic [ACC_W-1:0] acc, acc_sum;
    logic [CNT_W-1:0] avg_cnt, cnt_sum;
    logic [4:0]       tag;
    logic             restart;

    // A channel change (or an empty accumulator) starts a fresh sum with the current code.
    always_comb begin
        restart = (avg_cnt == '0) || (chan != tag);
        acc_sum = (restart ? '0 : acc) + ACC_W'(do_in[15:4]);
        cnt_sum = (restart ? '0 : avg_cnt) + CNT_W'(1);
    end

    always_ff @(posedge dclk_in or posedge reset_in) begin
        if (reset_in) begin
            acc              <= '0;
            avg_cnt          <= '0;
            tag              <= '0;
            sample_out       <= '0;
            sample_chan_out  <= '0;
            sample_valid_out <= 1'b0;
        end else begin
            sample_valid_out <= 1'b0;
            if (capture) begin
                tag <= chan;
                if (cnt_sum == DEPTH) begin
                    acc              <= '0;
                    avg_cnt          <= '0;
                    sample_out       <= 12'(acc_sum >> AVG_LOG2);
                    sample_chan_out  <= chan;
                    sample_valid_out <= 1'b1;
                end else begin
                    acc     <= acc_sum;
                    avg_cnt <= cnt_sum;
                end
            end
        end
    end
`else
    always_ff @(posedge dclk_in or posedge reset_in) begin
        if (reset_in) begin
            sample_out       <= '0;
            sample_chan_out  <= '0;
            sample_valid_out <= 1'b0;
        end else begin
            sample_valid_out <= capture;
            if (capture) begin
                sample_out      <= do_in[15:4];
                sample_chan_out <= chan;
            end
        end
    end
`endif

endmodule

// File: tb/tb_xadc_drp_sequencer.sv
// Self-checking bench for xadc_drp_sequencer: directed cases plus randomized traffic checked
// every cycle against a transaction-level model of read windows, overruns and sticky flags.
module tb_xadc_drp_sequencer;

    localparam int TIMEOUT_CYCLES = 64;
    localparam int AVG_LOG2       = 2;

    logic        dclk_in    = 1'b0;
    logic        reset_in   = 1'b1;
    logic        eoc_in     = 1'b0;
    logic [4:0]  channel_in = '0;
    logic        clr_err_in = 1'b0;
    logic [6:0]  daddr_out;
    logic        den_out, dwe_out;
    logic [15:0] di_out;
    logic [15:0] do_in;
    logic        drdy_in;
    logic [11:0] sample_out;
    logic [4:0]  sample_chan_out;
    logic        sample_valid_out, timeout_err_out, ovr_err_out;

    int n_cmp = 0;
    int n_bad = 0;

    xadc_drp_sequencer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .AVG_LOG2(AVG_LOG2)) dut (
        .dclk_in(dclk_in), .reset_in(reset_in), .eoc_in(eoc_in), .channel_in(channel_in),
        .clr_err_in(clr_err_in), .daddr_out(daddr_out), .den_out(den_out), .dwe_out(dwe_out),
        .di_out(di_out), .do_in(do_in), .drdy_in(drdy_in), .sample_out(sample_out),
        .sample_chan_out(sample_chan_out), .sample_valid_out(sample_valid_out),
        .timeout_err_out(timeout_err_out), .ovr_err_out(ovr_err_out)
    );

    always #5 dclk_in = ~dclk_in;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge dclk_in);
        #1;
    endtask

    // DRP slave model: answers each den pulse after a chosen number of cycles (0 = never).
    int          resp_lo = 1, resp_hi = 1;
    bit          resp_rand = 0, resp_fix = 0, spur_en = 0;
    logic [15:0] resp_data = '0;

    function automatic int pick_delay();
        int r;
        if (resp_rand) begin
            r = $urandom_range(0, 9);
            if (r < 7) return $urandom_range(1, 5);
            if (r < 9) return $urandom_range(60, 66);
            return 0;
        end
        if (resp_hi == 0) return 0;
        return $urandom_range(resp_lo, resp_hi);
    endfunction

    initial begin
        drdy_in = 1'b0;
        do_in   = '0;
        forever begin
            @(negedge dclk_in);
            if (den_out && !reset_in) begin
                int d;
                d = pick_delay();
                if (d > 0) begin
                    repeat (d) @(posedge dclk_in);
                    #1;
                    drdy_in = 1'b1;
                    do_in   = resp_fix ? resp_data : 16'($urandom);
                    @(posedge dclk_in);
                    #1;
                    drdy_in = 1'b0;
                end
            end else if (spur_en && $urandom_range(0, 9) == 0) begin
                @(posedge dclk_in);
                #1;
                drdy_in = 1'b1;
                do_in   = 16'($urandom);
                @(posedge dclk_in);
                #1;
                drdy_in = 1'b0;
            end
        end
    end

    // Reference model: a read accepted at cycle A requests at A+1 and may be answered in
    // A+2 .. A+TIMEOUT_CYCLES-1; without an answer the timeout flag appears at A+TIMEOUT_CYCLES+1.
    int          cyc = 0;
    bit          m_busy;
    int          m_acc_cyc;
    logic [4:0]  m_chan;
    int          m_sum, m_cnt;
    logic [4:0]  m_tag;
    bit          e_den, e_valid, e_to, e_ovr;
    logic [6:0]  e_addr;
    logic [11:0] e_smp;
    logic [4:0]  e_chan;
    int          den_count = 0, valid_count = 0;

    task automatic model_reset();
        m_busy = 0; m_acc_cyc = 0; m_chan = '0; m_sum = 0; m_cnt = 0; m_tag = '0;
        e_den = 0; e_valid = 0; e_to = 0; e_ovr = 0; e_addr = '0; e_smp = '0; e_chan = '0;
    endtask

    task automatic model_capture(input logic [11:0] code);
`ifdef XADC_AVG_EN
        if (m_cnt == 0 || m_chan != m_tag) begin
            m_sum = 0;
            m_cnt = 0;
        end
        m_tag = m_chan;
        m_sum += int'(code);
        m_cnt++;
        if (m_cnt == (1 << AVG_LOG2)) begin
            e_valid = 1;
            e_smp   = 12'(m_sum / (1 << AVG_LOG2));
            e_chan  = m_chan;
            m_sum   = 0;
            m_cnt   = 0;
        end
`else
        e_valid = 1;
        e_smp   = code;
        e_chan  = m_chan;
`endif
    endtask

    always @(negedge dclk_in) begin
        bit was_busy, waiting, to_set, ovr_set;
        cyc++;
        if (den_out) den_count++;
        if (sample_valid_out) valid_count++;
        if (reset_in) begin
            model_reset();
            check("rst_bus", {daddr_out, den_out, dwe_out, di_out}, '0);
            check("rst_sample", {sample_out, sample_chan_out, sample_valid_out}, '0);
            check("rst_flags", {timeout_err_out, ovr_err_out}, '0);
        end else begin
            check("den", den_out, e_den);
            check("daddr", daddr_out, e_addr);
            check("dwe_di", {dwe_out, di_out}, '0);
            check("valid", sample_valid_out, e_valid);
            check("sample", sample_out, e_smp);
            check("sample_chan", sample_chan_out, e_chan);
            check("timeout_err", timeout_err_out, e_to);
            check("ovr_err", ovr_err_out, e_ovr);
            was_busy = m_busy;
            waiting  = m_busy && (cyc >= m_acc_cyc + 2);
            to_set   = 0;
            ovr_set  = 0;
            e_valid  = 0;
            if (waiting && drdy_in) begin
                m_busy = 0;
                model_capture(do_in[15:4]);
            end else if (waiting && (cyc - m_acc_cyc - 1 == TIMEOUT_CYCLES - 1)) begin
                m_busy = 0;
                to_set = 1;
            end
            if (eoc_in) begin
                if (was_busy) begin
                    ovr_set = 1;
                end else begin
                    m_busy    = 1;
                    m_acc_cyc = cyc;
                    m_chan    = channel_in;
                    e_addr    = {2'b00, channel_in};
                end
            end
            e_den = m_busy && (m_acc_cyc == cyc);
            e_to  = to_set || (e_to && !clr_err_in);
            e_ovr = ovr_set || (e_ovr && !clr_err_in);
        end
    end

    task automatic do_read(input logic [4:0] ch, input logic [11:0] code);
        resp_lo = 2; resp_hi = 2; resp_fix = 1; resp_data = {code, 4'h5};
        step(); eoc_in = 1'b1; channel_in = ch;
        step(); eoc_in = 1'b0;
        repeat (5) step();
    endtask

    initial begin
        int v0, d0;
        bit got;
        repeat (3) @(posedge dclk_in);
        #1;
        check("reset_den", den_out, 1'b0);
        check("reset_valid", sample_valid_out, 1'b0);
        reset_in = 1'b0;
        repeat (2) step();

        // Single read, drdy three cycles after den.
        resp_lo = 3; resp_hi = 3; resp_fix = 1; resp_data = 16'hABC0;
        step(); eoc_in = 1'b1; channel_in = 5'h10;
        step(); eoc_in = 1'b0;
        #1;
        check("single_den_on", den_out, 1'b1);
        check("single_daddr", daddr_out, 7'h10);
        step(); #1; check("single_den_off", den_out, 1'b0);
        step(); step(); #1;
`ifndef XADC_AVG_EN
        check("single_no_early_valid", sample_valid_out, 1'b0);
`endif
        step(); #1;
`ifndef XADC_AVG_EN
        check("single_valid", sample_valid_out, 1'b1);
        check("single_sample", sample_out, 12'hABC);
        check("single_chan", sample_chan_out, 5'h10);
`endif
        step(); #1;
        check("single_valid_drop", sample_valid_out, 1'b0);
        check("single_daddr_hold", daddr_out, 7'h10);
`ifndef XADC_AVG_EN
        check("single_sample_hold", sample_out, 12'hABC);
`endif

        // Timeout: no drdy; flag visible TIMEOUT_CYCLES cycles after den.
        resp_hi = 0;
        v0 = valid_count;
        step(); eoc_in = 1'b1; channel_in = 5'h07;
        step(); eoc_in = 1'b0;
        repeat (62) step();
        step(); #1; check("tmo_flag_before", timeout_err_out, 1'b0);
        step(); #1; check("tmo_flag_set", timeout_err_out, 1'b1);
        check("tmo_no_strobe", valid_count - v0, 0);
        resp_lo = 2; resp_hi = 2; resp_fix = 0;
        step(); eoc_in = 1'b1; channel_in = 5'h11;
        step(); eoc_in = 1'b0;
        #1; check("tmo_next_den", den_out, 1'b1);
        check("tmo_next_daddr", daddr_out, 7'h11);
        repeat (5) step();
`ifndef XADC_AVG_EN
        check("tmo_next_strobe", valid_count - v0, 1);
`endif

        // Overrun: second eoc during WAIT_DRDY is dropped, first read completes.
        step(); clr_err_in = 1'b1;
        step(); clr_err_in = 1'b0;
        resp_lo = 5; resp_hi = 5;
        d0 = den_count; v0 = valid_count;
        step(); eoc_in = 1'b1; channel_in = 5'h01;
        step(); eoc_in = 1'b0;
        step();
        step(); eoc_in = 1'b1; channel_in = 5'h02;
        step(); eoc_in = 1'b0;
        #1; check("ovr_set", ovr_err_out, 1'b1);
        repeat (6) step();
        check("ovr_one_den", den_count - d0, 1);
`ifndef XADC_AVG_EN
        check("ovr_one_strobe", valid_count - v0, 1);
        check("ovr_first_chan", sample_chan_out, 5'h01);
`endif
        step(); clr_err_in = 1'b1;
        step(); clr_err_in = 1'b0;
        #1; check("ovr_cleared", ovr_err_out, 1'b0);
        step(); eoc_in = 1'b1; channel_in = 5'h03;
        step(); eoc_in = 1'b0;
        step();
        step(); eoc_in = 1'b1; clr_err_in = 1'b1;
        step(); eoc_in = 1'b0; clr_err_in = 1'b0;
        #1; check("ovr_set_beats_clr", ovr_err_out, 1'b1);
        repeat (6) step();

        // Async reset one cycle after den; the late drdy must be ignored.
        resp_lo = 3; resp_hi = 3; resp_fix = 1; resp_data = 16'hFFF0;
        v0 = valid_count;
        step(); eoc_in = 1'b1; channel_in = 5'h1F;
        step(); eoc_in = 1'b0;
        step(); #2; reset_in = 1'b1;
        #1;
        check("arst_daddr", daddr_out, 7'h00);
        check("arst_den", den_out, 1'b0);
        check("arst_sample", {sample_out, sample_chan_out, sample_valid_out}, '0);
        check("arst_flags", {timeout_err_out, ovr_err_out}, '0);
        step(); reset_in = 1'b0;
        repeat (4) step();
        check("arst_late_drdy_ignored", valid_count - v0, 0);

`ifdef XADC_AVG_EN
        // Four channel-3 codes average to 102; a channel change restarts without a strobe.
        v0 = valid_count;
        do_read(5'd3, 12'd100); do_read(5'd3, 12'd101);
        do_read(5'd3, 12'd102); do_read(5'd3, 12'd105);
        check("avg_one_strobe", valid_count - v0, 1);
        check("avg_value", sample_out, 12'd102);
        check("avg_chan", sample_chan_out, 5'd3);
        v0 = valid_count;
        do_read(5'd3, 12'd500); do_read(5'd4, 12'd200);
        check("avg_switch_no_strobe", valid_count - v0, 0);
        do_read(5'd4, 12'd201); do_read(5'd4, 12'd202); do_read(5'd4, 12'd203);
        check("avg_restart_strobe", valid_count - v0, 1);
        check("avg_restart_value", sample_out, 12'd201);
        check("avg_restart_chan", sample_chan_out, 5'd4);
`else
        // Back-to-back: a new eoc one cycle after each strobe.
        resp_lo = 1; resp_hi = 4; resp_fix = 0;
        v0 = valid_count;
        for (int i = 0; i < 16; i++) begin
            step(); eoc_in = 1'b1; channel_in = 5'($urandom);
            step(); eoc_in = 1'b0;
            got = 0;
            for (int k = 0; k < 20 && !got; k++) begin
                step(); #1;
                got = sample_valid_out;
            end
            check("b2b_strobe_seen", got, 1'b1);
        end
        step();
        check("b2b_strobes", valid_count - v0, 16);
        check("b2b_no_overrun", ovr_err_out, 1'b0);
`endif

        // Randomized traffic: overruns, spurious drdy, late answers, timeouts, clears.
        step(); clr_err_in = 1'b1;
        step(); clr_err_in = 1'b0;
        resp_rand = 1; resp_fix = 0; spur_en = 1;
        repeat (3000) begin
            step();
            eoc_in     = ($urandom_range(0, 5) == 0);
            channel_in = 5'($urandom);
            clr_err_in = ($urandom_range(0, 39) == 0);
        end
        step(); eoc_in = 1'b0; clr_err_in = 1'b0; spur_en = 0; resp_rand = 0;
        repeat (80) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
